// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS main controller
package mc_pkg;

    // Controller states; the numeric values are visible on state_o.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUOp from the main FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl to the datapath ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - combinational ALUOp/funct to ALUControl decode
// Ports:
//   alu_op      in  2  operation class from the main FSM
//   funct       in  6  instr[5:0], consulted only for ALUOp=10
//   alu_control out 3  ALU operation select
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS main controller (Moore FSM)
// Optional feature macro: MC_BNE_EN (adds bne, branching when zero=0).
// Ports:
//   clk, reset             clock; asynchronous active-high reset to FETCH
//   opcode, funct          instruction fields from the IR
//   zero                   ALU zero flag, used combinationally for pc_en
//   pc_en                  PC load = PCWrite | (Branch & branch_cond)
//   IorD, MemWrite         memory address select / write enable
//   IRWrite                instruction register load
//   RegDst, MemtoReg       register-file A3 / WD3 selects
//   RegWrite               register-file write enable
//   ALUSrcA, ALUSrcB       ALU operand selects
//   ALUControl             ALU operation
//   PCSrc                  next-PC source select
//   state_o                current state
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_en,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         PCSrc,
    output logic [STATE_W-1:0] state_o
);

    state_t     state;
    state_t     state_next;
    logic       pc_write;
    logic       branch;
    logic       branch_cond;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = S_FETCH;
        pc_write    = 1'b0;
        branch      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        alu_op      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                ALUSrcB    = 2'b01;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = S_BRANCH;
`endif
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                MemtoReg    = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                RegDst      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                PCSrc   = 2'b01;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSrc    = 2'b10;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // The IR still holds the branch instruction in BRANCH, so opcode picks the sense.
`ifdef MC_BNE_EN
    assign branch_cond = (opcode == OP_BNE) ? ~zero : zero;
`else
    assign branch_cond = zero;
`endif

    // Write enables are gated by reset so an aborted instruction commits nothing.
    assign pc_en    = ~reset & (pc_write | (branch & branch_cond));
    assign MemWrite = ~reset & mem_write_s;
    assign IRWrite  = ~reset & ir_write_s;
    assign RegWrite = ~reset & reg_write_s;
    assign state_o  = STATE_W'(state);

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic [3:0] state_o;

    int n_checks;
    int n_pass;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_en      (pc_en),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_state(input string tag, input logic [3:0] exp);
        tick();
        check(tag, 32'(state_o), 32'(exp));
    endtask

    task automatic check_fetch(input string tag);
        check({tag, ".state"},   32'(state_o), 32'd0);
        check({tag, ".IRWrite"}, 32'(IRWrite), 32'd1);
        check({tag, ".pc_en"},   32'(pc_en),   32'd1);
        check({tag, ".ALUSrcB"}, 32'(ALUSrcB), 32'd1);
        check({tag, ".aluctl"},  32'(ALUControl), 32'b010);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        opcode   = 6'b000000;
        funct    = 6'b000000;
        zero     = 1'b0;
        #3;
        check("rst.state",    32'(state_o),  32'd0);
        check("rst.IRWrite",  32'(IRWrite),  32'd0);
        check("rst.pc_en",    32'(pc_en),    32'd0);
        check("rst.RegWrite", 32'(RegWrite), 32'd0);
        check("rst.MemWrite", 32'(MemWrite), 32'd0);
        check("rst.ALUSrcB",  32'(ALUSrcB),  32'd1);
        tick();
        reset = 1'b0;
        #1;

        // lw: 0,1,2,3,4
        opcode = 6'b100011;
        check_fetch("lw.f");
        step_state("lw.s1", 4'd1);
        check("lw.dec.ALUSrcB", 32'(ALUSrcB), 32'd3);
        step_state("lw.s2", 4'd2);
        check("lw.adr.ALUSrcA", 32'(ALUSrcA), 32'd1);
        check("lw.adr.ALUSrcB", 32'(ALUSrcB), 32'd2);
        check("lw.adr.RegWrite", 32'(RegWrite), 32'd0);
        step_state("lw.s3", 4'd3);
        check("lw.rd.IorD", 32'(IorD), 32'd1);
        check("lw.rd.RegWrite", 32'(RegWrite), 32'd0);
        step_state("lw.s4", 4'd4);
        check("lw.wb.RegWrite", 32'(RegWrite), 32'd1);
        check("lw.wb.MemtoReg", 32'(MemtoReg), 32'd1);
        check("lw.wb.RegDst",   32'(RegDst),   32'd0);
        step_state("lw.end", 4'd0);
        check("lw.end.MemtoReg", 32'(MemtoReg), 32'd0);

        // sw: 0,1,2,5
        opcode = 6'b101011;
        step_state("sw.s1", 4'd1);
        step_state("sw.s2", 4'd2);
        step_state("sw.s5", 4'd5);
        check("sw.MemWrite", 32'(MemWrite), 32'd1);
        check("sw.IorD",     32'(IorD),     32'd1);
        check("sw.RegWrite", 32'(RegWrite), 32'd0);
        step_state("sw.end", 4'd0);
        check("sw.end.MemWrite", 32'(MemWrite), 32'd0);

        // R add, slt, unknown funct: 0,1,6,7
        opcode = 6'b000000;
        funct  = 6'b100000;
        step_state("add.s1", 4'd1);
        step_state("add.s6", 4'd6);
        check("add.aluctl",  32'(ALUControl), 32'b010);
        check("add.ALUSrcA", 32'(ALUSrcA),    32'd1);
        check("add.ALUSrcB", 32'(ALUSrcB),    32'd0);
        step_state("add.s7", 4'd7);
        check("add.RegWrite", 32'(RegWrite), 32'd1);
        check("add.RegDst",   32'(RegDst),   32'd1);
        check("add.MemtoReg", 32'(MemtoReg), 32'd0);
        step_state("add.end", 4'd0);

        funct = 6'b101010;
        step_state("slt.s1", 4'd1);
        step_state("slt.s6", 4'd6);
        check("slt.aluctl", 32'(ALUControl), 32'b111);
        step_state("slt.s7", 4'd7);
        step_state("slt.end", 4'd0);

        funct = 6'b100101;
        step_state("or.s1", 4'd1);
        step_state("or.s6", 4'd6);
        check("or.aluctl", 32'(ALUControl), 32'b001);
        step_state("or.s7", 4'd7);
        step_state("or.end", 4'd0);

        funct = 6'b111111;
        step_state("fx.s1", 4'd1);
        step_state("fx.s6", 4'd6);
        check("fx.aluctl", 32'(ALUControl), 32'b010);
        step_state("fx.s7", 4'd7);
        step_state("fx.end", 4'd0);

        // beq taken / not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        step_state("beq1.s1", 4'd1);
        step_state("beq1.s8", 4'd8);
        check("beq1.pc_en",  32'(pc_en),      32'd1);
        check("beq1.PCSrc",  32'(PCSrc),      32'd1);
        check("beq1.aluctl", 32'(ALUControl), 32'b110);
        step_state("beq1.end", 4'd0);
        zero = 1'b0;
        step_state("beq0.s1", 4'd1);
        check("beq0.dec.pc_en", 32'(pc_en), 32'd0);
        step_state("beq0.s8", 4'd8);
        check("beq0.pc_en", 32'(pc_en), 32'd0);
        step_state("beq0.end", 4'd0);

        // addi: 0,1,9,10
        opcode = 6'b001000;
        step_state("addi.s1", 4'd1);
        step_state("addi.s9", 4'd9);
        check("addi.ALUSrcB", 32'(ALUSrcB), 32'd2);
        check("addi.aluctl",  32'(ALUControl), 32'b010);
        step_state("addi.s10", 4'd10);
        check("addi.RegWrite", 32'(RegWrite), 32'd1);
        check("addi.RegDst",   32'(RegDst),   32'd0);
        step_state("addi.end", 4'd0);

        // j: 0,1,11
        opcode = 6'b000010;
        step_state("j.s1", 4'd1);
        step_state("j.s11", 4'd11);
        check("j.pc_en", 32'(pc_en), 32'd1);
        check("j.PCSrc", 32'(PCSrc), 32'd2);
        step_state("j.end", 4'd0);

        // unknown opcode: 2-cycle NOP, no writes
        opcode = 6'b111111;
        step_state("nop.s1", 4'd1);
        check("nop.MemWrite", 32'(MemWrite), 32'd0);
        check("nop.RegWrite", 32'(RegWrite), 32'd0);
        step_state("nop.end", 4'd0);
        check("nop.end.RegWrite", 32'(RegWrite), 32'd0);

        // bne with zero=0
        opcode = 6'b000101;
        zero   = 1'b0;
        step_state("bne.s1", 4'd1);
`ifdef MC_BNE_EN
        step_state("bne.s8", 4'd8);
        check("bne.pc_en", 32'(pc_en), 32'd1);
        zero = 1'b1;
        #1;
        check("bne.z1.pc_en", 32'(pc_en), 32'd0);
        step_state("bne.end", 4'd0);
`else
        step_state("bne.nop", 4'd0);
        check("bne.nop.RegWrite", 32'(RegWrite), 32'd0);
`endif

        // reset in the middle of MEMWB
        opcode = 6'b100011;
        step_state("rlw.s1", 4'd1);
        step_state("rlw.s2", 4'd2);
        step_state("rlw.s3", 4'd3);
        step_state("rlw.s4", 4'd4);
        check("rlw.RegWrite", 32'(RegWrite), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rmid.state",    32'(state_o),  32'd0);
        check("rmid.RegWrite", 32'(RegWrite), 32'd0);
        check("rmid.IRWrite",  32'(IRWrite),  32'd0);
        tick();
        check("rhold.state", 32'(state_o), 32'd0);
        reset = 1'b0;
        #1;
        check_fetch("rrel");
        step_state("rrel.s1", 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
